// File: rtl/seq_pkg.sv
// seq_pkg: shared FSM state type and default sizing for the serial pattern transmitter.
package seq_pkg;
  localparam int PAT_W_DEF = 8;
  localparam int GAP_CYC_DEF = 2;
  typedef enum logic [2:0] {IDLE, SHIFT, GAP, PARITY, DONE} state_t;
endpackage

// File: rtl/seq_cnt.sv
// seq_cnt: loadable down-counter with zero flag.
module seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         zero
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (load) q <= d;
    else if (en) q <= q - 1'b1;
  assign zero = q == '0;
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter with repetitions and idle gaps.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after every pass.
module seq_pattern_tx import seq_pkg::*; #(
  parameter int PAT_W = PAT_W_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [PAT_W-1:0]         pattern,
  input  logic [$clog2(PAT_W):0]   len,
  input  logic [3:0]               reps,
  output logic                     outbit,
  output logic                     outvalid,
  output logic                     busy,
  output logic                     done
);
  localparam int LW = $clog2(PAT_W) + 1;
  localparam int IW = PAT_W > 1 ? $clog2(PAT_W) : 1;
  localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
  state_t st, nst;
  logic [PAT_W-1:0] pat_r, mask;
  logic [IW-1:0] li_r, li_in, id, idx, im1;
  logic [LW-1:0] len_c;
  logic [3:0] rep_r;
  logic [GW-1:0] gcnt;
  logic cap, iload, ien, izero, gload, gen, gzero, rdec, nbit, pass_end;
  assign len_c = len > LW'(PAT_W) ? LW'(PAT_W) : len;
  assign li_in = IW'(len_c - 1'b1);
  assign mask = {PAT_W{1'b1}} >> (LW'(PAT_W) - len_c);
  assign im1 = IW'(idx - 1'b1);
  seq_cnt #(.W(IW)) u_bit (.clk(clk), .reset(reset), .load(iload), .en(ien), .d(id), .q(idx), .zero(izero));
  seq_cnt #(.W(GW)) u_gap (.clk(clk), .reset(reset), .load(gload), .en(gen), .d(GW'(GAP_CYC - 1)), .q(gcnt), .zero(gzero));
  always_comb begin
    nst = st;
    cap = 1'b0;
    iload = 1'b0;
    ien = 1'b0;
    id = li_r;
    gload = 1'b0;
    gen = 1'b0;
    rdec = 1'b0;
    nbit = 1'b0;
    pass_end = 1'b0;
    case (st)
      IDLE: if (start && len != '0) begin
        nst = SHIFT;
        cap = 1'b1;
        iload = 1'b1;
        id = li_in;
        nbit = pattern[li_in];
      end
      SHIFT: if (!izero) begin
        ien = 1'b1;
        nbit = pat_r[im1];
      end
`ifdef SEQ_TX_PARITY_EN
      else begin
        nst = PARITY;
        nbit = ^pat_r;
      end
`else
      else pass_end = 1'b1;
`endif
      GAP: if (gzero) begin
        nst = SHIFT;
        iload = 1'b1;
        nbit = pat_r[li_r];
      end else gen = 1'b1;
      PARITY: pass_end = 1'b1;
      DONE: nst = IDLE;
      default: nst = IDLE;
    endcase
    // End of a pass: either finish, rest in GAP, or restart the pattern immediately.
    if (pass_end) begin
      if (rep_r == '0) nst = DONE;
      else if (GAP_CYC > 0) begin
        rdec = 1'b1;
        nst = GAP;
        gload = 1'b1;
      end else begin
        rdec = 1'b1;
        nst = SHIFT;
        iload = 1'b1;
        nbit = pat_r[li_r];
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= IDLE;
      pat_r <= '0;
      li_r <= '0;
      rep_r <= '0;
      outbit <= 1'b0;
      outvalid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      st <= nst;
      if (cap) begin
        pat_r <= pattern & mask;
        li_r <= li_in;
        rep_r <= reps;
      end else if (rdec) rep_r <= rep_r - 1'b1;
      outbit <= nbit;
      outvalid <= nst == SHIFT || nst == PARITY;
      busy <= nst != IDLE;
      done <= nst == DONE;
    end
endmodule
